ble4_lut4_cfg_stage: RTL and testbench

//  LUT4 stage sitting directly upstream of the BLE4 flip-flop; its lut4_out drives ff_D.

---
 rtl/ble4_lut4_cfg_stage_if.sv | 30 +++
 rtl/ble4_lut4_cfg_stage.sv | 108 ++++++++++
 tb/tb_ble4_lut4_cfg_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ble4_lut4_cfg_stage_if.sv
// rtl/ble4_lut4_cfg_stage_if.sv - serial config-chain handshake bundle for the LUT4 stage
interface ble4_lut4_cfg_stage_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_data;
    logic cfg_ready;
    logic cfg_busy;
    logic cfg_done;
    logic ccff_tail;

    modport master (
        output cfg_start,
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  cfg_busy,
        input  cfg_done,
        input  ccff_tail
    );

    modport slave (
        input  cfg_start,
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output cfg_busy,
        output cfg_done,
        output ccff_tail
    );
endinterface

// File: rtl/ble4_lut4_cfg_stage.sv
// rtl/ble4_lut4_cfg_stage.sv - LUT4 with shadow-shifted, atomically committed truth table
module ble4_lut4_cfg_stage #(
    parameter int                   LUT_SIZE = 4,
    parameter int                   TT_BITS  = 16,
    parameter logic [TT_BITS-1:0]   RESET_TT = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset,
    ble4_lut4_cfg_stage_if.slave    cfg,
    input  logic [LUT_SIZE-1:0]     lut4_in,
    output logic                    lut4_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [LUT_SIZE-1:0] CNT_LAST = LUT_SIZE'(TT_BITS - 1);

    state_t                 state_q, state_d;
    logic [TT_BITS-1:0]     shadow_q, shadow_d;
    logic [TT_BITS-1:0]     active_q, active_d;
    logic [LUT_SIZE-1:0]    cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tail_q, tail_d;
    logic                   beat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= RESET_TT;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tail_q   <= tail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tail_d   = tail_q;
        beat     = cfg.cfg_valid & ready_q;

        case (state_q)
            IDLE: begin
                if (cfg.cfg_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (beat) begin
                    shadow_d = {cfg.cfg_data, shadow_q[TT_BITS-1:1]};
                    tail_d   = shadow_q[0];
                    cnt_d    = cnt_q + 1'b1;
                    // Last beat: drop ready on the same edge so no 17th bit can slip in.
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                        ready_d = 1'b0;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_busy  = busy_q;
    assign cfg.cfg_done  = done_q;
    assign cfg.ccff_tail = tail_q;

    // Only the committed table is visible downstream; the shadow never reaches ff_D.
    assign lut4_out = active_q[lut4_in];

endmodule

// File: tb/tb_ble4_lut4_cfg_stage.sv
// tb/tb_ble4_lut4_cfg_stage.sv - bench for ble4_lut4_cfg_stage against a bit-history model
module tb_ble4_lut4_cfg_stage;

    localparam logic [15:0] RST_TT = 16'hA5A5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lut4_in;
    logic       lut4_out;

    ble4_lut4_cfg_stage_if cfg ();

    ble4_lut4_cfg_stage #(
        .LUT_SIZE (4),
        .TT_BITS  (16),
        .RESET_TT (RST_TT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg      (cfg.slave),
        .lut4_in  (lut4_in),
        .lut4_out (lut4_out)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          hist[$];
    logic [15:0] model_tt;
    logic        exp_tail;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            lut4_in = 4'(i);
            #1;
            check(tag, {15'd0, lut4_out}, {15'd0, model_tt[i]});
        end
    endtask

    task automatic start_load();
        cfg.cfg_start = 1'b1;
        tick();
        cfg.cfg_start = 1'b0;
        check("start_ready", {15'd0, cfg.cfg_ready}, 16'd1);
        check("start_busy", {15'd0, cfg.cfg_busy}, 16'd1);
    endtask

    // mode 0: back-to-back, 1: gap before every beat, 2: random gaps with stray starts, 3: random gaps
    task automatic send(input logic [15:0] tt, input int mode, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (mode == 1 || (mode >= 2 && $urandom_range(0, 1) == 1)) begin
                cfg.cfg_valid = 1'b0;
                cfg.cfg_data  = 1'($urandom);
                if (mode == 2) cfg.cfg_start = 1'b1;
                tick();
                cfg.cfg_start = 1'b0;
                lut4_in = 4'($urandom);
                #1;
                check("gap_old_table", {15'd0, lut4_out}, {15'd0, model_tt[lut4_in]});
                check("gap_ready", {15'd0, cfg.cfg_ready}, 16'd1);
                check("gap_tail", {15'd0, cfg.ccff_tail}, {15'd0, exp_tail});
            end
            cfg.cfg_valid = 1'b1;
            cfg.cfg_data  = tt[i];
            tick();
            hist.push_back(tt[i]);
            exp_tail = (hist.size() >= 17) ? hist[hist.size() - 17] : 1'b0;
            check("beat_tail", {15'd0, cfg.ccff_tail}, {15'd0, exp_tail});
            if (i < 15) check("beat_ready", {15'd0, cfg.cfg_ready}, 16'd1);
        end
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic finish_commit();
        logic [15:0] new_tt;
        check("commit_ready", {15'd0, cfg.cfg_ready}, 16'd0);
        check("commit_busy", {15'd0, cfg.cfg_busy}, 16'd1);
        check("commit_done", {15'd0, cfg.cfg_done}, 16'd0);
        check("commit_old_table", {15'd0, lut4_out}, {15'd0, model_tt[lut4_in]});
        for (int k = 0; k < 16; k++) new_tt[k] = hist[hist.size() - 16 + k];
        model_tt = new_tt;
        tick();
        check("done_high", {15'd0, cfg.cfg_done}, 16'd1);
        check("done_busy", {15'd0, cfg.cfg_busy}, 16'd0);
        check("done_new_table", {15'd0, lut4_out}, {15'd0, model_tt[lut4_in]});
        tick();
        check("done_low", {15'd0, cfg.cfg_done}, 16'd0);
    endtask

    task automatic load(input logic [15:0] tt, input int mode);
        start_load();
        send(tt, mode, 16);
        finish_commit();
        sweep("table_sweep");
    endtask

    initial begin
        reset         = 1'b0;
        cfg.cfg_start = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = 1'b0;
        lut4_in       = 4'd0;
        model_tt      = RST_TT;
        exp_tail      = 1'b0;
        #12;

        check("rst_ready", {15'd0, cfg.cfg_ready}, 16'd0);
        check("rst_busy", {15'd0, cfg.cfg_busy}, 16'd0);
        check("rst_done", {15'd0, cfg.cfg_done}, 16'd0);
        check("rst_tail", {15'd0, cfg.ccff_tail}, 16'd0);
        sweep("rst_sweep");
        @(negedge clk);
        reset = 1'b1;
        tick();

        load(16'h8000, 0);
        load(16'h6996, 1);
        load(16'h00FF, 0);
        load(16'h1234, 0);

        start_load();
        send(16'h5A3C, 3, 7);
        #2;
        reset = 1'b0;
        #1;
        hist.delete();
        model_tt = RST_TT;
        exp_tail = 1'b0;
        check("midrst_ready", {15'd0, cfg.cfg_ready}, 16'd0);
        check("midrst_busy", {15'd0, cfg.cfg_busy}, 16'd0);
        check("midrst_tail", {15'd0, cfg.ccff_tail}, 16'd0);
        sweep("midrst_sweep");
        @(negedge clk);
        reset = 1'b1;
        tick();
        load(16'hFFFE, 0);

        cfg.cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg.cfg_data = 1'($urandom);
            tick();
            check("idle_valid_ready", {15'd0, cfg.cfg_ready}, 16'd0);
            check("idle_valid_busy", {15'd0, cfg.cfg_busy}, 16'd0);
            check("idle_valid_tail", {15'd0, cfg.ccff_tail}, {15'd0, exp_tail});
        end
        cfg.cfg_valid = 1'b0;
        load(16'($urandom), 2);

        for (int r = 0; r < 4; r++) load(16'($urandom), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
